// File: rtl/occamy_rule_demux.sv
// Address-rule request demultiplexer with per-ID ordering, an internal error slot
// for unmapped requests, and a round-robin registered response path.
module occamy_rule_demux #(
    parameter int unsigned NumMstPorts  = 4,
    parameter int unsigned NumRules     = 4,
    parameter int unsigned AddrWidth    = 48,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned MaxTxnsPerId = 4,
    localparam int unsigned IdxW        = $clog2(NumMstPorts),
    localparam int unsigned CntW        = $clog2(MaxTxnsPerId + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumRules*AddrWidth-1:0]    rule_start_i,
    input  logic [NumRules*AddrWidth-1:0]    rule_end_i,
    input  logic [NumRules*IdxW-1:0]         rule_idx_i,
    input  logic                             en_default_i,
    input  logic [IdxW-1:0]                  default_port_i,
    input  logic                             slv_req_valid_i,
    output logic                             slv_req_ready_o,
    input  logic [AddrWidth-1:0]             slv_req_addr_i,
    input  logic [IdWidth-1:0]               slv_req_id_i,
    output logic [NumMstPorts-1:0]           mst_req_valid_o,
    input  logic [NumMstPorts-1:0]           mst_req_ready_i,
    output logic [AddrWidth-1:0]             mst_req_addr_o,
    output logic [IdWidth-1:0]               mst_req_id_o,
    input  logic [NumMstPorts-1:0]           mst_rsp_valid_i,
    output logic [NumMstPorts-1:0]           mst_rsp_ready_o,
    input  logic [NumMstPorts*IdWidth-1:0]   mst_rsp_id_i,
    input  logic [NumMstPorts*DataWidth-1:0] mst_rsp_data_i,
    input  logic [NumMstPorts-1:0]           mst_rsp_err_i,
    output logic                             slv_rsp_valid_o,
    input  logic                             slv_rsp_ready_i,
    output logic [IdWidth-1:0]               slv_rsp_id_o,
    output logic [DataWidth-1:0]             slv_rsp_data_o,
    output logic                             slv_rsp_err_o
);

    localparam int NumIds  = 1 << IdWidth;
    localparam int NumCand = NumMstPorts + 1;
    localparam int ArbW    = $clog2(NumCand);

    // Target encoding: MSB set means the internal error slot.
    logic [CntW-1:0]      cnt_q  [NumIds];
    logic [IdxW:0]        port_q [NumIds];
    logic                 err_pend_q;
    logic [IdWidth-1:0]   err_id_q;
    logic [ArbW-1:0]      rr_q;
    logic                 rsp_valid_q;
    logic [IdWidth-1:0]   rsp_id_q;
    logic [DataWidth-1:0] rsp_data_q;
    logic                 rsp_err_q;

    logic [IdxW-1:0]      tgt_port;
    logic                 tgt_err;
    logic [IdxW:0]        req_tgt;
    logic [CntW-1:0]      cur_cnt;
    logic                 stall;
    logic                 req_hs;

    logic [NumCand-1:0]   cand_valid;
    logic                 gnt_found;
    logic [ArbW-1:0]      gnt_idx;
    logic [IdWidth-1:0]   cand_id;
    logic [DataWidth-1:0] cand_data;
    logic                 cand_err;
    logic                 load_en;
    logic [NumIds-1:0]    inc_vec;
    logic [NumIds-1:0]    dec_vec;

    assign mst_req_addr_o = slv_req_addr_i;
    assign mst_req_id_o   = slv_req_id_i;

    // Later rules override earlier ones, so the highest matching index wins.
    always_comb begin
        tgt_port = default_port_i;
        tgt_err  = !en_default_i;
        for (int r = 0; r < int'(NumRules); r++) begin
            if (slv_req_addr_i >= rule_start_i[r*AddrWidth +: AddrWidth] &&
                slv_req_addr_i <  rule_end_i[r*AddrWidth +: AddrWidth]) begin
                tgt_port = rule_idx_i[r*IdxW +: IdxW];
                tgt_err  = 1'b0;
            end
        end
    end

    assign req_tgt = {tgt_err, tgt_port};
    assign cur_cnt = cnt_q[slv_req_id_i];
    assign stall   = (cur_cnt != '0 && port_q[slv_req_id_i] != req_tgt) ||
                     (cur_cnt == CntW'(MaxTxnsPerId));

    always_comb begin
        mst_req_valid_o = '0;
        slv_req_ready_o = 1'b0;
        if (rst_ni && slv_req_valid_i && !stall) begin
            if (tgt_err) begin
                slv_req_ready_o = !err_pend_q;
            end else begin
                for (int p = 0; p < int'(NumMstPorts); p++) begin
                    if (tgt_port == IdxW'(p)) begin
                        mst_req_valid_o[p] = 1'b1;
                        slv_req_ready_o    = mst_req_ready_i[p];
                    end
                end
            end
        end
    end

    assign req_hs = slv_req_valid_i && slv_req_ready_o;

    assign cand_valid = {err_pend_q, mst_rsp_valid_i};

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int j = 0; j < NumCand; j++) begin
            if (!gnt_found && cand_valid[(int'(rr_q) + j) % NumCand]) begin
                gnt_found = 1'b1;
                gnt_idx   = ArbW'((int'(rr_q) + j) % NumCand);
            end
        end
    end

    // Defaults describe the error slot; a real port overrides them.
    always_comb begin
        cand_id   = err_id_q;
        cand_data = '0;
        cand_err  = 1'b1;
        for (int i = 0; i < int'(NumMstPorts); i++) begin
            if (gnt_idx == ArbW'(i)) begin
                cand_id   = mst_rsp_id_i[i*IdWidth +: IdWidth];
                cand_data = mst_rsp_data_i[i*DataWidth +: DataWidth];
                cand_err  = mst_rsp_err_i[i];
            end
        end
    end

    assign load_en = rst_ni && gnt_found && (!rsp_valid_q || slv_rsp_ready_i);

    always_comb begin
        mst_rsp_ready_o = '0;
        for (int i = 0; i < int'(NumMstPorts); i++) begin
            mst_rsp_ready_o[i] = load_en && (gnt_idx == ArbW'(i));
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NumIds; i++) begin
            inc_vec[i] = req_hs && (slv_req_id_i == IdWidth'(i));
            dec_vec[i] = load_en && (cand_id == IdWidth'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIds; i++) begin
                cnt_q[i]  <= '0;
                port_q[i] <= '0;
            end
            err_pend_q  <= 1'b0;
            err_id_q    <= '0;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // Simultaneous inc/dec cancels; a stray response never underflows.
            for (int i = 0; i < NumIds; i++) begin
                if (inc_vec[i]) port_q[i] <= req_tgt;
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (!inc_vec[i] && dec_vec[i] && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (load_en && gnt_idx == ArbW'(NumMstPorts)) err_pend_q <= 1'b0;
            if (req_hs && tgt_err) begin
                err_pend_q <= 1'b1;
                err_id_q   <= slv_req_id_i;
            end
            if (load_en) begin
                rr_q        <= (gnt_idx == ArbW'(NumMstPorts)) ? '0 : gnt_idx + 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= cand_id;
                rsp_data_q  <= cand_data;
                rsp_err_q   <= cand_err;
            end else if (slv_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign slv_rsp_valid_o = rsp_valid_q;
    assign slv_rsp_id_o    = rsp_id_q;
    assign slv_rsp_data_o  = rsp_data_q;
    assign slv_rsp_err_o   = rsp_err_q;

endmodule

// File: doc/occamy_rule_demux.md
OCCAMY_RULE_DEMUX -- requirements
Module: occamy_rule_demux

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- NumMstPorts, 4, downstream ports (>=2).
- NumRules, 4, address rules.
- AddrWidth, 48, address bits.
- IdWidth, 4, transaction ID bits.
- DataWidth, 64, response data bits.
- MaxTxnsPerId, 4, outstanding limit per ID.
REQ-002 The module SHALL define IdxW = clog2(NumMstPorts) and CntW = clog2(MaxTxnsPerId+1).
REQ-003 One clock; reset is synchronous and active-low, with ports named clk_i and rst_ni.
REQ-004 The module SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_ni, in, 1, sync active-low reset.
- rule_start_i, in, NumRules*AddrWidth, inclusive rule start.
- rule_end_i, in, NumRules*AddrWidth, exclusive rule end.
- rule_idx_i, in, NumRules*IdxW, target port per rule.
- en_default_i, in, 1, route unmatched requests to the default port.
- default_port_i, in, IdxW, default port.
- slv_req_valid_i / slv_req_ready_o, in/out, 1, upstream request handshake.
- slv_req_addr_i, in, AddrWidth, request address.
- slv_req_id_i, in, IdWidth, request ID.
- mst_req_valid_o / mst_req_ready_i, out/in, NumMstPorts, per-port request handshake.
- mst_req_addr_o / mst_req_id_o, out, AddrWidth / IdWidth, broadcast copy of the upstream request.
- mst_rsp_valid_i / mst_rsp_ready_o, in/out, NumMstPorts, per-port response handshake.
- mst_rsp_id_i, in, NumMstPorts*IdWidth, response IDs.
- mst_rsp_data_i, in, NumMstPorts*DataWidth, response data.
- mst_rsp_err_i, in, NumMstPorts, response error flags.
- slv_rsp_valid_o / slv_rsp_ready_i, out/in, 1, upstream response handshake.
- slv_rsp_id_o / slv_rsp_data_o / slv_rsp_err_o, out, IdWidth / DataWidth / 1, registered response.

Function
REQ-005 Decode SHALL be combinational: rule r matches when rule_start <= addr < rule_end; on overlap the highest matching r wins; an empty rule (end <= start) never matches.
REQ-006 An unmatched request SHALL go to default_port_i when en_default_i=1, and to the internal error slot otherwise.
REQ-007 Per ID the block SHALL track cnt[id] (CntW bits) and port[id] (IdxW bits plus an error-slot flag).
REQ-008 A request SHALL stall, with no mst_req_valid_o and slv_req_ready_o=0, when cnt[id]>0 and the target differs from port[id], or when cnt[id]==MaxTxnsPerId.
REQ-009 A request that is not stalled and targets port p SHALL drive mst_req_valid_o[p]=1 (all other bits 0) with slv_req_ready_o=mst_req_ready_i[p], with zero added latency.
REQ-010 The block SHALL never deassert mst_req_valid_o[p] without a handshake while slv_req_valid_i stays high and the request is unchanged.
REQ-011 On a request handshake the block SHALL increment cnt[id] and load port[id].
REQ-012 On a response handshake the block SHALL decrement cnt[rsp_id].
REQ-013 A same-cycle increment and decrement of the same ID SHALL leave cnt unchanged, and port[id] SHALL be reloaded.
REQ-014 An error-slot request SHALL be accepted immediately (ready=1) when no error is pending.
REQ-015 An accepted error-slot request SHALL set err_pend and latch its ID.
REQ-016 While err_pend=1, further error-slot requests SHALL see ready=0.
REQ-017 err_pend SHALL raise a response candidate with data=0 and err=1, and SHALL clear when that candidate is granted.
REQ-018 Response arbitration SHALL be round-robin over NumMstPorts+1 candidates, the error slot being index NumMstPorts; the pointer SHALL advance to the granted index + 1 (modulo NumMstPorts+1) on grant.
REQ-019 The response output register SHALL load the granted candidate when empty or draining in the same cycle.
REQ-020 mst_rsp_ready_o SHALL be asserted only to the granted port, giving 1-cycle latency and full throughput.
REQ-021 A response with an ID whose cnt==0 SHALL still be forwarded, and cnt SHALL stay at 0 (no underflow).
REQ-022 The block SHALL accept simultaneous request and response handshakes every cycle.

Reset
REQ-023 While rst_ni=0 at a clock edge the block SHALL clear all cnt, port, err_pend, the RR pointer and slv_rsp_valid_o.
REQ-024 During reset slv_req_ready_o, mst_req_valid_o and mst_rsp_ready_o SHALL read 0.
REQ-025 Reset mid-transaction SHALL discard all outstanding state without emitting responses.

Verification
REQ-026 Rules {[0x1000,0x2000)->1, [0x1800,0x3000)->2}, addr 0x1900 -> mst_req_valid_o=0b0100 (rule 1 wins).
REQ-027 en_default_i=0, addr 0x9000, id 3 -> accepted, 1 cycle later err_pend; slv_rsp valid with id=3, err=1, data=0 after arbitration.
REQ-028 ID 5 outstanding at port 0, new ID-5 request to port 2 -> stalled until port-0 response handshake, then forwarded the same cycle cnt reaches 0.
REQ-029 MaxTxnsPerId=4: four ID-1 requests to port 1 accepted, fifth stalled; one response -> fifth accepted.
REQ-030 All ports respond continuously with slv_rsp_ready_i=1 -> grants 0,1,2,3,0,... one per cycle; slv_rsp_ready_i=0 for 3 cycles -> output held stable, no mst_rsp_ready_o.
REQ-031 rst_ni=0 for one cycle with 3 outstanding -> all counters 0; a next request with any ID to any port is accepted immediately.
